instr_cache_mp: RTL

Parametrised, read-only, direct-mapped instruction cache serving `NUM_REQS` requesters through a round-robin arbiter. It sits between the fetch units of several warps or cores and one memory port. It replaces the fixed single-requester icache wrapper with a self-contained blocking cache that also provides flush and hit/miss performance counters.

---
 rtl/instr_cache_mp.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_cache_mp.sv
// Blocking, read-only, direct-mapped instruction cache shared by NUM_REQS fetch
// channels through a round-robin arbiter, with invalidate-all and hit/miss counters.
//   state  | meaning
//   IDLE   | start a pending flush, else grant one requester
//   LOOKUP | compare tag, count hit or miss
//   MREQ   | issue line fill request to memory
//   MWAIT  | wait for fill data, install line
//   RESP   | hold response until the owning channel accepts it
//   FLUSH  | clear all valid bits, pulse flush_done
module instr_cache_mp #(
    parameter int NUM_REQS   = 2,
    parameter int NUM_LINES  = 64,
    parameter int LINE_SIZE  = 16,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQS-1:0]                   core_req_valid,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]        core_req_addr,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]         core_req_tag,
    output logic [NUM_REQS-1:0]                   core_req_ready,
    output logic [NUM_REQS-1:0]                   core_rsp_valid,
    output logic [WORD_SIZE*8-1:0]                core_rsp_data,
    output logic [TAG_WIDTH-1:0]                  core_rsp_tag,
    input  logic [NUM_REQS-1:0]                   core_rsp_ready,
    output logic                                  mem_req_valid,
    output logic [ADDR_WIDTH-$clog2(LINE_SIZE/WORD_SIZE)-1:0] mem_req_addr,
    input  logic                                  mem_req_ready,
    input  logic                                  mem_rsp_valid,
    input  logic [LINE_SIZE*8-1:0]                mem_rsp_data,
    output logic                                  mem_rsp_ready,
    input  logic                                  flush,
    output logic                                  flush_done,
    output logic [31:0]                           hit_count,
    output logic [31:0]                           miss_count
);
    localparam int WPL       = LINE_SIZE / WORD_SIZE;
    localparam int OFS       = $clog2(WPL);
    localparam int IDX       = $clog2(NUM_LINES);
    localparam int CTAG      = ADDR_WIDTH - IDX - OFS;
    localparam int OFS_W     = (OFS > 0) ? OFS : 1;
    localparam int RW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int WORD_BITS = WORD_SIZE * 8;
    localparam int LINE_BITS = LINE_SIZE * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MREQ,
        S_MWAIT,
        S_RESP,
        S_FLUSH
    } state_e;

    state_e                 state_q, state_d;
    logic [RW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]          id_q, id_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [WORD_BITS-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [31:0]            hit_q, hit_d;
    logic [31:0]            miss_q, miss_d;

    logic [CTAG-1:0]        tag_mem_q  [NUM_LINES];
    logic [LINE_BITS-1:0]   data_mem_q [NUM_LINES];

    logic [OFS_W-1:0]       line_off;
    logic [IDX-1:0]         line_idx;
    logic [CTAG-1:0]        line_tag;
    logic                   hit;
    logic                   gnt_found;
    logic [RW-1:0]          gnt_id;
    logic [RW-1:0]          cand;
    logic                   fill;

    assign line_off = (OFS > 0) ? addr_q[OFS_W-1:0] : '0;
    assign line_idx = addr_q[OFS +: IDX];
    assign line_tag = addr_q[ADDR_WIDTH-1 -: CTAG];
    assign hit      = valid_q[line_idx] && (tag_mem_q[line_idx] == line_tag);
    assign fill     = (state_q == S_MWAIT) && mem_rsp_valid;

    assign mem_req_addr  = addr_q[ADDR_WIDTH-1:OFS];
    assign core_rsp_data = rsp_data_q;
    assign core_rsp_tag  = tag_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        addr_d         = addr_q;
        tag_d          = tag_q;
        rsp_data_d     = rsp_data_q;
        valid_d        = valid_q;
        flush_pend_d   = flush_pend_q | flush;
        hit_d          = hit_q;
        miss_d         = miss_q;
        core_req_ready = '0;
        core_rsp_valid = '0;
        mem_req_valid  = 1'b0;
        mem_rsp_ready  = 1'b0;
        flush_done     = 1'b0;
        gnt_found      = 1'b0;
        gnt_id         = '0;
        cand           = '0;

        // first valid channel at or after rr_ptr
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = RW'((int'(rr_ptr_q) + k) % NUM_REQS);
            if (!gnt_found && core_req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (flush_pend_q || flush) begin
                    state_d = S_FLUSH;
                end else if (gnt_found) begin
                    core_req_ready[gnt_id] = 1'b1;
                    addr_d   = core_req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                    tag_d    = core_req_tag[gnt_id*TAG_WIDTH +: TAG_WIDTH];
                    id_d     = gnt_id;
                    rr_ptr_d = RW'((int'(gnt_id) + 1) % NUM_REQS);
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    rsp_data_d = data_mem_q[line_idx][line_off*WORD_BITS +: WORD_BITS];
                    if (hit_q != 32'hFFFF_FFFF) hit_d = hit_q + 32'd1;
                    state_d = S_RESP;
                end else begin
                    if (miss_q != 32'hFFFF_FFFF) miss_d = miss_q + 32'd1;
                    state_d = S_MREQ;
                end
            end
            S_MREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = S_MWAIT;
            end
            S_MWAIT: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) begin
                    valid_d[line_idx] = 1'b1;
                    rsp_data_d = mem_rsp_data[line_off*WORD_BITS +: WORD_BITS];
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                core_rsp_valid[id_q] = 1'b1;
                if (core_rsp_ready[id_q]) state_d = S_IDLE;
            end
            S_FLUSH: begin
                valid_d      = '0;
                flush_done   = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            addr_q       <= '0;
            tag_q        <= '0;
            rsp_data_q   <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            rsp_data_q   <= rsp_data_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // arrays carry no reset; a line is only trusted once its valid bit is set
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem_q[line_idx]  <= line_tag;
            data_mem_q[line_idx] <= mem_rsp_data;
        end
    end

endmodule
